// File: rtl/rgb2gray_pipe.sv
// -----------------------------------------------------------------------------
// rgb2gray_pipe
//
// Three-stage pipelined RGB to single-channel converter with a valid/ready
// handshake and a per-frame pixel counter.
//
// Modes (captured with each accepted pixel):
//   000 R bypass, 001 G bypass, 010 B bypass,
//   011 BT.601 luma  (77R + 150G + 29B + 128) >> 8,
//   100 average      (85R +  85G + 86B + 128) >> 8,
//   101..111 luma; with RGB2GRAY_INVERT_EN defined, 101 is inverted luma.
//
// Optional feature macro: RGB2GRAY_INVERT_EN
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   r_data_in      in   red component   [WIDTH-1:0]
//   g_data_in      in   green component [WIDTH-1:0]
//   b_data_in      in   blue component  [WIDTH-1:0]
//   mode           in   conversion mode [2:0]
//   data_in_done   in   input valid
//   data_in_ready  out  input accepted this cycle
//   data_out       out  converted sample [WIDTH-1:0]
//   data_out_done  out  output valid
//   data_out_ready in   downstream accepts output this cycle
//   pixel_count    out  output transfers so far in the frame [CNT_W-1:0]
//   frame_done     out  one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module rgb2gray_pipe #(
  parameter int WIDTH        = 8,
  parameter int FRAME_PIXELS = 2073600,
  parameter int CNT_W        = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r_data_in,
  input  logic [WIDTH-1:0] g_data_in,
  input  logic [WIDTH-1:0] b_data_in,
  input  logic [2:0]       mode,
  input  logic             data_in_done,
  output logic             data_in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_done,
  input  logic             data_out_ready,
  output logic [CNT_W-1:0] pixel_count,
  output logic             frame_done
);

  localparam int PW = WIDTH + 8;   // product width
  localparam int SW = WIDTH + 10;  // sum width

  localparam logic [WIDTH-1:0] MAX_VAL   = '1;
  localparam logic [SW-1:0]    ROUND     = SW'(128);
  localparam logic [SW-1:0]    MAX_WIDE  = SW'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    MODE_R    = 3'b000,
    MODE_G    = 3'b001,
    MODE_B    = 3'b010,
    MODE_LUMA = 3'b011,
    MODE_AVG  = 3'b100,
    MODE_INV  = 3'b101
  } mode_e;

  // The whole pipe moves as one; a full output slot that is not being taken
  // freezes every stage, bubbles included.
  logic advance;
  assign advance       = !data_out_done || data_out_ready;
  assign data_in_ready = advance;

  // ---------------------------------------------------------------------------
  // S1: capture pixel and mode
  // ---------------------------------------------------------------------------
  logic             v1;
  logic [WIDTH-1:0] r1, g1, b1;
  logic [2:0]       mode1;

  // NOTE: only valid bits (and the architecturally visible outputs) are reset;
  // datapath registers are qualified by their valid bit and need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
    end else if (advance) begin
      v1 <= data_in_done;
    end
    if (advance) begin
      r1    <= r_data_in;
      g1    <= g_data_in;
      b1    <= b_data_in;
      mode1 <= mode;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: coefficient select and products
  // ---------------------------------------------------------------------------
  logic [7:0]       coef_r, coef_g, coef_b;
  logic             byp_sel;
  logic [WIDTH-1:0] byp_val;
`ifdef RGB2GRAY_INVERT_EN
  logic             inv_sel;
`endif

  // NOTE: every output of a combinational block gets a default first so no
  // latch can be inferred for an unlisted case.
  always_comb begin
    coef_r  = 8'd77;
    coef_g  = 8'd150;
    coef_b  = 8'd29;
    byp_sel = 1'b0;
    byp_val = r1;
`ifdef RGB2GRAY_INVERT_EN
    inv_sel = 1'b0;
`endif
    case (mode1)
      MODE_R: begin
        byp_sel = 1'b1;
        byp_val = r1;
      end
      MODE_G: begin
        byp_sel = 1'b1;
        byp_val = g1;
      end
      MODE_B: begin
        byp_sel = 1'b1;
        byp_val = b1;
      end
      MODE_AVG: begin
        coef_r = 8'd85;
        coef_g = 8'd85;
        coef_b = 8'd86;
      end
`ifdef RGB2GRAY_INVERT_EN
      MODE_INV: inv_sel = 1'b1;
`endif
      default: ;  // MODE_LUMA and unused codes keep the luma defaults
    endcase
  end

  logic             v2;
  logic [PW-1:0]    p_r, p_g, p_b;
  logic             byp2;
  logic [WIDTH-1:0] byp_val2;
`ifdef RGB2GRAY_INVERT_EN
  logic             inv2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
    end else if (advance) begin
      v2 <= v1;
    end
    if (advance) begin
      p_r      <= PW'(r1) * PW'(coef_r);
      p_g      <= PW'(g1) * PW'(coef_g);
      p_b      <= PW'(b1) * PW'(coef_b);
      byp2     <= byp_sel;
      byp_val2 <= byp_val;
`ifdef RGB2GRAY_INVERT_EN
      inv2     <= inv_sel;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // S3: sum, round, saturate (and optional invert) into data_out
  // ---------------------------------------------------------------------------
  logic [SW-1:0]    sum;
  logic [SW-1:0]    shifted;
  logic [WIDTH-1:0] sat;
  logic [WIDTH-1:0] result;

  always_comb begin
    sum     = SW'(p_r) + SW'(p_g) + SW'(p_b) + ROUND;
    shifted = sum >> 8;
    sat     = (shifted > MAX_WIDE) ? MAX_VAL : shifted[WIDTH-1:0];
`ifdef RGB2GRAY_INVERT_EN
    // Inversion follows saturation so it always lands inside 0..MAX_VAL.
    result  = byp2 ? byp_val2 : (inv2 ? (MAX_VAL - sat) : sat);
`else
    result  = byp2 ? byp_val2 : sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_done <= 1'b0;
      data_out      <= '0;
    end else if (advance) begin
      data_out_done <= v2;
      // A bubble leaves the last sample in place; only done qualifies it.
      if (v2) begin
        data_out <= result;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter
  // ---------------------------------------------------------------------------
  logic out_xfer;
  assign out_xfer = data_out_done && data_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_xfer) begin
        if (pixel_count == CNT_LAST) begin
          pixel_count <= '0;
          frame_done  <= 1'b1;
        end else begin
          pixel_count <= pixel_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// -----------------------------------------------------------------------------
// tb_rgb2gray_pipe
//
// Directed self-checking bench for rgb2gray_pipe, built with FRAME_PIXELS=4.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_rgb2gray_pipe;

  logic        clk;
  logic        reset;
  logic [7:0]  r_data_in, g_data_in, b_data_in;
  logic [2:0]  mode;
  logic        data_in_done;
  logic        data_in_ready;
  logic [7:0]  data_out;
  logic        data_out_done;
  logic        data_out_ready;
  logic [21:0] pixel_count;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  rgb2gray_pipe #(
    .WIDTH        (8),
    .FRAME_PIXELS (4),
    .CNT_W        (22)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .r_data_in      (r_data_in),
    .g_data_in      (g_data_in),
    .b_data_in      (b_data_in),
    .mode           (mode),
    .data_in_done   (data_in_done),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_done  (data_out_done),
    .data_out_ready (data_out_ready),
    .pixel_count    (pixel_count),
    .frame_done     (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    data_in_done   = 1'b0;
    data_out_ready = 1'b1;
    r_data_in      = '0;
    g_data_in      = '0;
    b_data_in      = '0;
    mode           = 3'b000;
    step();
    step();
    reset = 1'b0;
  endtask

  // Sends one pixel into an empty pipe and reports the first output and the
  // number of edges from the input transfer (lat = -1 if none within bound).
  task automatic run_single(input logic [7:0] rr, input logic [7:0] gg,
                            input logic [7:0] bb, input logic [2:0] mm,
                            output logic [7:0] got, output int lat);
    r_data_in      = rr;
    g_data_in      = gg;
    b_data_in      = bb;
    mode           = mm;
    data_in_done   = 1'b1;
    data_out_ready = 1'b1;
    got            = '0;
    lat            = -1;
    step();
    data_in_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (data_out_done) begin
        lat = c;
        got = data_out;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    data_in_done   = 1'b0;
    data_out_ready = 1'b0;
    step();
    n_cmp++; if (data_out_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", data_out_done); end
    n_cmp++; if (data_out !== 8'd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", data_out); end
    n_cmp++; if (pixel_count !== 22'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", pixel_count); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame got %b want 0", frame_done); end
    n_cmp++; if (data_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", data_in_ready); end
    reset = 1'b0;
    data_out_ready = 1'b1;
    step();
  endtask

  task automatic test_luma();
    logic [7:0] got;
    int lat;
    do_reset();
    run_single(8'd100, 8'd50, 8'd200, 3'b011, got, lat);
    n_cmp++; if (got !== 8'd82) begin n_bad++; $display("FAIL luma_mid got %0d want 82", got); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL luma_latency got %0d want 3", lat); end
    run_single(8'd255, 8'd255, 8'd255, 3'b011, got, lat);
    n_cmp++; if (got !== 8'd255) begin n_bad++; $display("FAIL luma_white got %0d want 255", got); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL luma_white_latency got %0d want 3", lat); end
    run_single(8'd0, 8'd0, 8'd0, 3'b011, got, lat);
    n_cmp++; if (got !== 8'd0) begin n_bad++; $display("FAIL luma_black got %0d want 0", got); end
    // Unused mode code falls back to luma.
    run_single(8'd100, 8'd50, 8'd200, 3'b111, got, lat);
    n_cmp++; if (got !== 8'd82) begin n_bad++; $display("FAIL mode111 got %0d want 82", got); end
  endtask

  task automatic test_modes_back_to_back();
    logic [2:0] modes [4] = '{3'b100, 3'b000, 3'b001, 3'b010};
    logic [7:0] exp   [4] = '{8'd117, 8'd100, 8'd50, 8'd200};
    logic [7:0] got [$];
    do_reset();
    r_data_in = 8'd100;
    g_data_in = 8'd50;
    b_data_in = 8'd200;
    data_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        mode = modes[i];
        data_in_done = 1'b1;
      end else begin
        data_in_done = 1'b0;
      end
      #1;
      if (data_out_done && data_out_ready) got.push_back(data_out);
      step();
    end
    n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL modes_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL modes_out[%0d] got %0d want %0d", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [10] = '{8'd10, 8'd17, 8'd24, 8'd31, 8'd38,
                             8'd45, 8'd52, 8'd59, 8'd66, 8'd73};
    logic [7:0] got [$];
    logic [7:0] held;
    int idx;
    logic in_x, out_x, stall;
    do_reset();
    idx  = 0;
    held = '0;
    r_data_in = 8'd1;
    b_data_in = 8'd2;
    mode      = 3'b001;
    for (int cyc = 0; cyc < 60 && got.size() < 10; cyc++) begin
      stall = (cyc >= 5 && cyc < 10);
      data_out_ready = !stall;
      if (idx < 10) begin
        g_data_in    = exp[idx];
        data_in_done = 1'b1;
      end else begin
        data_in_done = 1'b0;
      end
      #1;
      if (stall) begin
        n_cmp++; if (data_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc %0d got %b want 0", cyc, data_in_ready); end
        n_cmp++; if (data_out_done !== 1'b1) begin n_bad++; $display("FAIL bp_out_done cyc %0d got %b want 1", cyc, data_out_done); end
        if (cyc == 5) held = data_out;
        else begin
          n_cmp++; if (data_out !== held) begin n_bad++; $display("FAIL bp_hold cyc %0d got %0d want %0d", cyc, data_out, held); end
        end
      end
      in_x  = data_in_done && data_in_ready;
      out_x = data_out_done && data_out_ready;
      if (out_x) got.push_back(data_out);
      step();
      if (in_x) idx++;
    end
    data_in_done = 1'b0;
    data_out_ready = 1'b1;
    n_cmp++; if (got.size() !== 10) begin n_bad++; $display("FAIL bp_count got %0d want 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_bad++; $display("FAIL bp_out[%0d] got %0d want %0d", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_frame();
    int pulses [$];
    int n_out;
    int n_in;
    logic in_x;
    do_reset();
    n_out = 0;
    n_in  = 0;
    mode  = 3'b000;
    data_out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (n_in < 9) begin
        r_data_in    = 8'(n_in + 1);
        data_in_done = 1'b1;
      end else begin
        data_in_done = 1'b0;
      end
      #1;
      in_x = data_in_done && data_in_ready;
      if (data_out_done && data_out_ready) n_out++;
      step();
      if (in_x) n_in++;
      if (frame_done) pulses.push_back(n_out);
    end
    n_cmp++; if (n_out !== 9) begin n_bad++; $display("FAIL frame_transfers got %0d want 9", n_out); end
    n_cmp++; if (pulses.size() !== 2) begin n_bad++; $display("FAIL frame_pulses got %0d want 2", pulses.size()); end
    if (pulses.size() == 2) begin
      n_cmp++; if (pulses[0] !== 4) begin n_bad++; $display("FAIL frame_pulse0 after %0d want 4", pulses[0]); end
      n_cmp++; if (pulses[1] !== 8) begin n_bad++; $display("FAIL frame_pulse1 after %0d want 8", pulses[1]); end
    end
    n_cmp++; if (pixel_count !== 22'd1) begin n_bad++; $display("FAIL frame_count_end got %0d want 1", pixel_count); end
  endtask

  task automatic test_reset_mid();
    int stale;
    do_reset();
    mode = 3'b000;
    data_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r_data_in    = 8'(30 + i);
      data_in_done = 1'b1;
      step();
    end
    data_in_done = 1'b0;
    n_cmp++; if (data_out_done !== 1'b1) begin n_bad++; $display("FAIL mid_pre_done got %b want 1", data_out_done); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (data_out_done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b want 0", data_out_done); end
    n_cmp++; if (pixel_count !== 22'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", pixel_count); end
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (data_out_done) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL mid_stale got %0d want 0", stale); end
  endtask

  task automatic test_invert();
    logic [7:0] got;
    logic [7:0] want;
    int lat;
`ifdef RGB2GRAY_INVERT_EN
    want = 8'd173;
`else
    want = 8'd82;
`endif
    do_reset();
    run_single(8'd100, 8'd50, 8'd200, 3'b101, got, lat);
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL mode101 got %0d want %0d", got, want); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mode101_latency got %0d want 3", lat); end
  endtask

  initial begin
    reset          = 1'b1;
    r_data_in      = '0;
    g_data_in      = '0;
    b_data_in      = '0;
    mode           = 3'b000;
    data_in_done   = 1'b0;
    data_out_ready = 1'b0;
    #1;
    test_reset();
    test_luma();
    test_modes_back_to_back();
    test_backpressure();
    test_frame();
    test_reset_mid();
    test_invert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
